ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port (CPU A / video B) front end for a single-command memory controller; strobe to mem_req is 2 cycles.
// No backpressure: A is held off by a_wait, extra B strobes are dropped with b_overrun, a stuck controller is aborted by a watchdog.
module ram_port_arbiter #(
  parameter int ADDR_W     = 21,
  parameter int STARVE_MAX = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_rd_n,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_di,
  output logic [7:0]        a_do,
  output logic              a_wait,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [7:0]        b_do,
  output logic              b_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic              b_overrun,
  output logic              timeout_err
);

  localparam int SKIP_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int WD_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_e;

  state_e              state_q, state_d;
  logic                owner_b_q, owner_b_d;
  logic                a_pend_q, a_pend_d;
  logic                a_rd_n_q, a_rd_n_d;
  logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
  logic [7:0]          a_di_q, a_di_d;
  logic                b_pend_q, b_pend_d;
  logic [ADDR_W-1:0]   b_addr_q, b_addr_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                a_wait_q, a_wait_d;
  logic [7:0]          a_do_q, a_do_d;
  logic [7:0]          b_do_q, b_do_d;
  logic                b_valid_q, b_valid_d;
  logic                b_overrun_q, b_overrun_d;
  logic                timeout_err_q, timeout_err_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_din_q, mem_din_d;

  logic                b_busy;
  logic                grant_b;
  logic [7:0]          rdata;

  always_comb begin
    state_d       = state_q;
    owner_b_d     = owner_b_q;
    a_pend_d      = a_pend_q;
    a_rd_n_d      = a_rd_n_q;
    a_addr_d      = a_addr_q;
    a_di_d        = a_di_q;
    b_pend_d      = b_pend_q;
    b_addr_d      = b_addr_q;
    skip_cnt_d    = skip_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    a_wait_d      = a_wait_q;
    a_do_d        = a_do_q;
    b_do_d        = b_do_q;
    b_valid_d     = 1'b0;
    b_overrun_d   = 1'b0;
    timeout_err_d = 1'b0;
    mem_req_d     = 1'b0;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    grant_b       = 1'b0;
    rdata         = 8'hFF;

    // B counts as busy only while pending or actually owning the controller;
    // in the completion cycle the FSM is already back in IDLE.
    b_busy = b_pend_q || ((state_q != IDLE) && owner_b_q);

    if (a_req && !a_wait_q) begin
      a_pend_d = 1'b1;
      a_wait_d = 1'b1;
      a_rd_n_d = a_rd_n;
      a_addr_d = a_addr;
      a_di_d   = a_di;
    end

    if (b_req) begin
      if (b_busy) begin
        b_overrun_d = 1'b1;
      end else begin
        b_pend_d = 1'b1;
        b_addr_d = b_addr;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (a_pend_q || b_pend_q) begin
          grant_b   = b_pend_q && !(a_pend_q && (skip_cnt_q == SKIP_W'(STARVE_MAX)));
          state_d   = ISSUE;
          owner_b_d = grant_b;
          mem_req_d = 1'b1;
          if (grant_b) begin
            mem_we_d   = 1'b0;
            mem_addr_d = b_addr_q;
            b_pend_d   = 1'b0;
            // Only reached below STARVE_MAX, so the count saturates there.
            if (a_pend_q) begin
              skip_cnt_d = skip_cnt_q + SKIP_W'(1);
            end
          end else begin
            mem_we_d   = a_rd_n_q;
            mem_addr_d = a_addr_q;
            mem_din_d  = a_di_q;
            a_pend_d   = 1'b0;
            skip_cnt_d = '0;
          end
        end
      end
      ISSUE: begin
        state_d  = WAIT_ACK;
        wd_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (mem_ack || (wd_cnt_q == WD_W'(TIMEOUT - 1))) begin
          rdata         = mem_ack ? mem_dout : 8'hFF;
          timeout_err_d = !mem_ack;
          state_d       = IDLE;
          if (owner_b_q) begin
            b_do_d    = rdata;
            b_valid_d = 1'b1;
          end else begin
            a_wait_d = 1'b0;
            if (!mem_we_q) begin
              a_do_d = rdata;
            end
          end
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_b_q     <= 1'b0;
      a_pend_q      <= 1'b0;
      a_rd_n_q      <= 1'b0;
      a_addr_q      <= '0;
      a_di_q        <= '0;
      b_pend_q      <= 1'b0;
      b_addr_q      <= '0;
      skip_cnt_q    <= '0;
      wd_cnt_q      <= '0;
      a_wait_q      <= 1'b0;
      a_do_q        <= 8'h00;
      b_do_q        <= 8'h00;
      b_valid_q     <= 1'b0;
      b_overrun_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
    end else begin
      state_q       <= state_d;
      owner_b_q     <= owner_b_d;
      a_pend_q      <= a_pend_d;
      a_rd_n_q      <= a_rd_n_d;
      a_addr_q      <= a_addr_d;
      a_di_q        <= a_di_d;
      b_pend_q      <= b_pend_d;
      b_addr_q      <= b_addr_d;
      skip_cnt_q    <= skip_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      a_wait_q      <= a_wait_d;
      a_do_q        <= a_do_d;
      b_do_q        <= b_do_d;
      b_valid_q     <= b_valid_d;
      b_overrun_q   <= b_overrun_d;
      timeout_err_q <= timeout_err_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
    end
  end

  assign a_do        = a_do_q;
  assign a_wait      = a_wait_q;
  assign b_do        = b_do_q;
  assign b_valid     = b_valid_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign b_overrun   = b_overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: inputs change 1 time unit after each rising edge,
// so every check sees the registered state of the current cycle.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 21;

  logic              clk;
  logic              reset;
  logic              a_req;
  logic              a_rd_n;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_di;
  logic [7:0]        a_do;
  logic              a_wait;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_do;
  logic              b_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_ack;
  logic [7:0]        mem_dout;
  logic              b_overrun;
  logic              timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_mreq  = 0;
  int mreq_base;

  ram_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(2),
    .TIMEOUT   (255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_req      (a_req),
    .a_rd_n     (a_rd_n),
    .a_addr     (a_addr),
    .a_di       (a_di),
    .a_do       (a_do),
    .a_wait     (a_wait),
    .b_req      (b_req),
    .b_addr     (b_addr),
    .b_do       (b_do),
    .b_valid    (b_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_ack    (mem_ack),
    .mem_dout   (mem_dout),
    .b_overrun  (b_overrun),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req === 1'b1) n_mreq++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; a_req = 1'b0; a_rd_n = 1'b0; a_addr = '0; a_di = '0;
    b_req = 1'b0; b_addr = '0; mem_ack = 1'b0; mem_dout = '0;
    tick(); tick();

    // strobes during the reset cycle must be ignored
    a_req = 1'b1; a_addr = 21'h00ABC; b_req = 1'b1; b_addr = 21'h00DEF;
    tick();
    reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    chk_eq("rst_a_wait", a_wait, 0);
    chk_eq("rst_b_valid", b_valid, 0);
    chk_eq("rst_mem_req", mem_req, 0);
    chk_eq("rst_mem_we", mem_we, 0);
    chk_eq("rst_b_overrun", b_overrun, 0);
    chk_eq("rst_timeout_err", timeout_err, 0);
    chk_eq("rst_a_do", a_do, 0);
    chk_eq("rst_b_do", b_do, 0);
    chk_eq("rst_mem_addr", mem_addr, 0);
    chk_eq("rst_mem_din", mem_din, 0);
    tick();
    chk_eq("rst_strobe_no_req", mem_req, 0);
    chk_eq("rst_strobe_no_wait", a_wait, 0);
    tick();
    chk_eq("rst_strobe_no_req2", mem_req, 0);

    // A read alone; ack 3 cycles after mem_req
    a_req = 1'b1; a_rd_n = 1'b0; a_addr = 21'h01234;
    tick();
    a_req = 1'b0;
    chk_eq("rd_wait_n1", a_wait, 1);
    chk_eq("rd_noreq_n1", mem_req, 0);
    tick();
    chk_eq("rd_req_n2", mem_req, 1);
    chk_eq("rd_we", mem_we, 0);
    chk_eq("rd_addr", mem_addr, 32'h01234);
    tick();
    chk_eq("rd_req_one_cycle", mem_req, 0);
    tick(); tick();
    chk_eq("rd_wait_before_ack", a_wait, 1);
    mem_ack = 1'b1; mem_dout = 8'h5A;
    tick();
    mem_ack = 1'b0;
    chk_eq("rd_wait_done", a_wait, 0);
    chk_eq("rd_a_do", a_do, 32'h5A);
    // new A strobe in the completion cycle is accepted
    a_req = 1'b1; a_rd_n = 1'b0; a_addr = 21'h00042;
    tick();
    a_req = 1'b0;
    chk_eq("rd2_wait", a_wait, 1);
    tick();
    chk_eq("rd2_req", mem_req, 1);
    chk_eq("rd2_addr", mem_addr, 32'h42);
    tick();
    mem_ack = 1'b1; mem_dout = 8'hA5;
    tick();
    mem_ack = 1'b0;
    chk_eq("rd2_wait_done", a_wait, 0);
    chk_eq("rd2_a_do", a_do, 32'hA5);
    tick();

    // simultaneous A write and B read: B first, A second
    a_req = 1'b1; a_rd_n = 1'b1; a_addr = 21'h00AAA; a_di = 8'h3C;
    b_req = 1'b1; b_addr = 21'h1F000;
    tick();
    a_req = 1'b0; b_req = 1'b0;
    chk_eq("both_a_wait", a_wait, 1);
    tick();
    chk_eq("both_b_req", mem_req, 1);
    chk_eq("both_b_we", mem_we, 0);
    chk_eq("both_b_addr", mem_addr, 32'h1F000);
    chk_eq("both_skip1", 32'(dut.skip_cnt_q), 1);
    tick();
    mem_ack = 1'b1; mem_dout = 8'h77;
    tick();
    mem_ack = 1'b0;
    chk_eq("both_b_valid", b_valid, 1);
    chk_eq("both_b_do", b_do, 32'h77);
    chk_eq("both_a_still_wait", a_wait, 1);
    tick();
    chk_eq("both_a_req", mem_req, 1);
    chk_eq("both_a_we", mem_we, 1);
    chk_eq("both_a_addr", mem_addr, 32'h00AAA);
    chk_eq("both_a_din", mem_din, 32'h3C);
    chk_eq("both_skip0", 32'(dut.skip_cnt_q), 0);
    chk_eq("both_b_valid_pulse", b_valid, 0);
    tick();
    mem_ack = 1'b1; mem_dout = 8'h99;
    tick();
    mem_ack = 1'b0;
    chk_eq("wr_wait_done", a_wait, 0);
    chk_eq("wr_a_do_held", a_do, 32'hA5);
    tick();

    // B re-strobes after each completion; A wins the third arbitration
    b_req = 1'b1; b_addr = 21'h00100;
    tick();
    b_req = 1'b0;
    tick();
    chk_eq("st_b1_addr", mem_addr, 32'h00100);
    chk_eq("st_b1_skip", 32'(dut.skip_cnt_q), 0);
    tick();
    mem_ack = 1'b1; mem_dout = 8'h11;
    tick();
    mem_ack = 1'b0;
    chk_eq("st_b1_valid", b_valid, 1);
    a_req = 1'b1; a_rd_n = 1'b0; a_addr = 21'h00200;
    b_req = 1'b1; b_addr = 21'h00300;
    tick();
    a_req = 1'b0; b_req = 1'b0;
    chk_eq("st_a_wait", a_wait, 1);
    chk_eq("st_idle_gap", mem_req, 0);
    tick();
    chk_eq("st_b2_req", mem_req, 1);
    chk_eq("st_b2_addr", mem_addr, 32'h00300);
    chk_eq("st_b2_skip", 32'(dut.skip_cnt_q), 1);
    tick();
    mem_ack = 1'b1; mem_dout = 8'h22;
    tick();
    mem_ack = 1'b0;
    chk_eq("st_b2_do", b_do, 32'h22);
    b_req = 1'b1; b_addr = 21'h00400;
    tick();
    b_req = 1'b0;
    chk_eq("st_a_req", mem_req, 1);
    chk_eq("st_a_addr", mem_addr, 32'h00200);
    chk_eq("st_a_skip", 32'(dut.skip_cnt_q), 0);
    chk_eq("st_b3_accepted", b_overrun, 0);
    tick();
    mem_ack = 1'b1; mem_dout = 8'h33;
    tick();
    mem_ack = 1'b0;
    chk_eq("st_a_done", a_wait, 0);
    chk_eq("st_a_do", a_do, 32'h33);
    tick();
    chk_eq("st_b3_req", mem_req, 1);
    chk_eq("st_b3_addr", mem_addr, 32'h00400);
    tick();
    mem_ack = 1'b1; mem_dout = 8'h44;
    tick();
    mem_ack = 1'b0;
    chk_eq("st_b3_valid", b_valid, 1);
    chk_eq("st_b3_do", b_do, 32'h44);
    tick();

    // second B strobe while B in flight is dropped
    mreq_base = n_mreq;
    b_req = 1'b1; b_addr = 21'h00500;
    tick();
    b_req = 1'b0;
    tick();
    chk_eq("ov_req", mem_req, 1);
    tick();
    b_req = 1'b1; b_addr = 21'h00600;
    tick();
    b_req = 1'b0;
    chk_eq("ov_pulse", b_overrun, 1);
    tick();
    chk_eq("ov_pulse_end", b_overrun, 0);
    mem_ack = 1'b1; mem_dout = 8'h55;
    tick();
    mem_ack = 1'b0;
    chk_eq("ov_b_valid", b_valid, 1);
    chk_eq("ov_b_do", b_do, 32'h55);
    tick(); tick(); tick();
    chk_eq("ov_one_cmd", n_mreq - mreq_base, 1);

    // watchdog abort on an A read
    a_req = 1'b1; a_rd_n = 1'b0; a_addr = 21'h00777;
    tick();
    a_req = 1'b0;
    tick();
    chk_eq("to_req", mem_req, 1);
    repeat (255) tick();
    chk_eq("to_wait_last", a_wait, 1);
    chk_eq("to_not_yet", timeout_err, 0);
    tick();
    chk_eq("to_err", timeout_err, 1);
    chk_eq("to_wait_done", a_wait, 0);
    chk_eq("to_a_do", a_do, 32'hFF);
    chk_eq("to_idle", 32'(dut.state_q), 0);
    // stray ack while idle
    mem_ack = 1'b1; mem_dout = 8'hEE;
    tick();
    mem_ack = 1'b0;
    chk_eq("to_err_pulse", timeout_err, 0);
    chk_eq("stray_a_do", a_do, 32'hFF);
    chk_eq("stray_b_valid", b_valid, 0);
    chk_eq("stray_wait", a_wait, 0);
    tick();

    // reset while waiting for ack, then a late ack
    a_req = 1'b1; a_rd_n = 1'b0; a_addr = 21'h00888;
    tick();
    a_req = 1'b0;
    tick();
    chk_eq("mr_req", mem_req, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_dout = 8'h66;
    chk_eq("mr_wait_cleared", a_wait, 0);
    tick();
    mem_ack = 1'b0;
    chk_eq("mr_b_valid", b_valid, 0);
    chk_eq("mr_a_wait", a_wait, 0);
    chk_eq("mr_a_do", a_do, 0);
    chk_eq("mr_b_do", b_do, 0);
    chk_eq("mr_timeout", timeout_err, 0);
    chk_eq("mr_mem_addr", mem_addr, 0);
    chk_eq("mr_idle", 32'(dut.state_q), 0);
    tick();
    chk_eq("mr_no_req", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
